// File: rtl/dot_product_engine.sv
// dot_product_engine: LANES-wide multiply-accumulate of two buffered vectors, results queued in a FIFO.
// Define DOTP_SATURATE_EN to clip results to OUT_WIDTH instead of keeping the low bits.
module dot_product_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int VECTOR_LEN = 8,
    parameter int LANES      = 2,
    parameter int RES_DEPTH  = 16,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [$clog2(VECTOR_LEN)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data_a,
    input  logic [DATA_WIDTH-1:0]           wr_data_b,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    input  logic                            rd_en,
    output logic [OUT_WIDTH-1:0]            rd_data,
    output logic                            rd_valid,
    output logic [$clog2(RES_DEPTH):0]      res_count,
    output logic                            full,
    output logic                            ovf_err,
    output logic                            sat_flag
);
    localparam int IDX_W = $clog2(VECTOR_LEN);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ACC_W = 2 * DATA_WIDTH + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_LEN - LANES);

    typedef enum logic [1:0] {IDLE, COMPUTE, STORE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_mem [VECTOR_LEN];
    logic [DATA_WIDTH-1:0] b_mem [VECTOR_LEN];
    logic [OUT_WIDTH-1:0]  res_mem [RES_DEPTH];
    logic [ACC_W-1:0]      acc_q, acc_d, lane_sum;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [OUT_WIDTH-1:0]  rd_data_q, rd_data_d, res_val;
    logic                  rd_valid_q, rd_valid_d, done_q, done_d;
    logic                  ovf_q, ovf_d, sat_q, sat_d, res_sat;
    logic                  accept, push, pop;

    assign full   = count_q == CNT_W'(RES_DEPTH);
    assign accept = state_q == IDLE && start && !full;
    assign push   = state_q == STORE;
    assign pop    = rd_en && count_q != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
        end
    end

    // Storage arrays are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && wr_en) begin
            a_mem[wr_addr] <= wr_data_a;
            b_mem[wr_addr] <= wr_data_b;
        end
        if (push) res_mem[wr_ptr_q] <= res_val;
    end

    always_comb begin
        state_d = state_q == IDLE    ? (accept ? COMPUTE : IDLE) :
                  state_q == COMPUTE ? (idx_q == LAST_IDX ? STORE : COMPUTE) : IDLE;
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++)
            lane_sum = lane_sum + ACC_W'(a_mem[idx_q + IDX_W'(l)]) * ACC_W'(b_mem[idx_q + IDX_W'(l)]);
    end

`ifdef DOTP_SATURATE_EN
    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'({OUT_WIDTH{1'b1}});
    assign res_sat = acc_q > OUT_MAX;
    assign res_val = res_sat ? '1 : acc_q[OUT_WIDTH-1:0];
`else
    assign res_sat = 1'b0;
    assign res_val = acc_q[OUT_WIDTH-1:0];
`endif

    // The index wraps to zero after the last group, which is harmless since STORE follows.
    always_comb begin
        acc_d      = accept ? '0 : state_q == COMPUTE ? acc_q + lane_sum : acc_q;
        idx_d      = accept ? '0 : state_q == COMPUTE ? idx_q + IDX_W'(LANES) : idx_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_data_d  = pop ? res_mem[rd_ptr_q] : rd_data_q;
        rd_valid_d = pop;
        done_d     = push;
        ovf_d      = ovf_q | (state_q == IDLE && start && full);
        sat_d      = push ? res_sat : sat_q;
    end

    always_comb begin
        busy      = state_q != IDLE;
        done      = done_q;
        rd_data   = rd_data_q;
        rd_valid  = rd_valid_q;
        res_count = count_q;
        ovf_err   = ovf_q;
        sat_flag  = sat_q;
    end
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: directed checks of dot_product_engine at LANES=2 (main), 1 and 8.
module tb_dot_product_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_a = '0, wr_b = '0;
    logic [2:0]  start_v = '0, rd_en_v = '0;
    logic [2:0]  busy_v, done_v, rd_valid_v, full_v, ovf_v, sat_v;
    logic [15:0] rd_data_v [3];
    logic [4:0]  res_count_v [3];
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    dot_product_engine #(.LANES(2)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_a(wr_a), .wr_data_b(wr_b),
        .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]), .rd_en(rd_en_v[0]),
        .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]), .res_count(res_count_v[0]),
        .full(full_v[0]), .ovf_err(ovf_v[0]), .sat_flag(sat_v[0]));
    dot_product_engine #(.LANES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_a(wr_a), .wr_data_b(wr_b),
        .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]), .rd_en(rd_en_v[1]),
        .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]), .res_count(res_count_v[1]),
        .full(full_v[1]), .ovf_err(ovf_v[1]), .sat_flag(sat_v[1]));
    dot_product_engine #(.LANES(8)) dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_a(wr_a), .wr_data_b(wr_b),
        .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]), .rd_en(rd_en_v[2]),
        .rd_data(rd_data_v[2]), .rd_valid(rd_valid_v[2]), .res_count(res_count_v[2]),
        .full(full_v[2]), .ovf_err(ovf_v[2]), .sat_flag(sat_v[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input int a, input int b);
        wr_en = 1'b1;
        wr_addr = 3'(addr);
        wr_a = 8'(a);
        wr_b = 8'(b);
        tick();
        wr_en = 1'b0;
    endtask

    // Any write already on the bus is applied in the same cycle as the start.
    task automatic do_start(input int u, input int exp_lat);
        int lat;
        lat = 0;
        start_v[u] = 1'b1;
        tick();
        start_v[u] = 1'b0;
        wr_en = 1'b0;
        chk("busy_after_start", 32'(busy_v[u]), 1);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            if (done_v[u]) lat = n;
            else tick();
        end
        chk("done_latency", lat, exp_lat);
        chk("busy_at_done", 32'(busy_v[u]), 0);
        tick();
        chk("done_one_cycle", 32'(done_v[u]), 0);
    endtask

    task automatic pop_chk(input int u, input int exp);
        rd_en_v[u] = 1'b1;
        tick();
        rd_en_v[u] = 1'b0;
        chk("pop_valid", 32'(rd_valid_v[u]), 1);
        chk("pop_data", 32'(rd_data_v[u]), exp);
    endtask

    initial begin
        int seen;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy_v[0]), 0);
        chk("rst_done", 32'(done_v[0]), 0);
        chk("rst_rd_valid", 32'(rd_valid_v[0]), 0);
        chk("rst_rd_data", 32'(rd_data_v[0]), 0);
        chk("rst_count", 32'(res_count_v[0]), 0);
        chk("rst_full", 32'(full_v[0]), 0);
        chk("rst_ovf", 32'(ovf_v[0]), 0);
        chk("rst_sat", 32'(sat_v[0]), 0);

        // A=1..8, B=1; last element written in the start cycle
        for (int i = 0; i < 7; i++) wr(i, i + 1, 1);
        wr_en = 1'b1; wr_addr = 3'd7; wr_a = 8'd8; wr_b = 8'd1;
        do_start(0, 6);
        chk("count_one", 32'(res_count_v[0]), 1);
        pop_chk(0, 36);
        chk("sat_small", 32'(sat_v[0]), 0);

        // all 255: clipped or truncated
        for (int i = 0; i < 8; i++) wr(i, 255, 255);
        do_start(0, 6);
`ifdef DOTP_SATURATE_EN
        chk("sat_max", 32'(sat_v[0]), 1);
        pop_chk(0, 65535);
`else
        chk("sat_max", 32'(sat_v[0]), 0);
        pop_chk(0, 61448);
`endif

        // pop while empty: no valid, data held
        rd_en_v[0] = 1'b1;
        tick();
        rd_en_v[0] = 1'b0;
        chk("empty_valid", 32'(rd_valid_v[0]), 0);
`ifdef DOTP_SATURATE_EN
        chk("empty_hold", 32'(rd_data_v[0]), 65535);
`else
        chk("empty_hold", 32'(rd_data_v[0]), 61448);
`endif

        // fill the FIFO (pointers wrap), then overflow
        for (int i = 0; i < 8; i++) wr(i, 0, 1);
        for (int i = 0; i < 16; i++) begin
            wr(0, i * 3 + 1, 1);
            do_start(0, 6);
        end
        chk("full_flag", 32'(full_v[0]), 1);
        chk("full_count", 32'(res_count_v[0]), 16);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk("ovf_busy", 32'(busy_v[0]), 0);
        chk("ovf_set", 32'(ovf_v[0]), 1);
        tick();
        chk("ovf_busy_later", 32'(busy_v[0]), 0);
        chk("ovf_count", 32'(res_count_v[0]), 16);
        for (int i = 0; i < 16; i++) pop_chk(0, i * 3 + 1);
        chk("drained_count", 32'(res_count_v[0]), 0);
        chk("drained_full", 32'(full_v[0]), 0);
        chk("ovf_sticky", 32'(ovf_v[0]), 1);

        // push and pop in the same cycle at count 3
        for (int i = 0; i < 3; i++) begin
            wr(0, 100 + i, 1);
            do_start(0, 6);
        end
        wr(0, 103, 1);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_pp_count", 32'(res_count_v[0]), 3);
        rd_en_v[0] = 1'b1;
        tick();
        rd_en_v[0] = 1'b0;
        chk("pp_done", 32'(done_v[0]), 1);
        chk("pp_count", 32'(res_count_v[0]), 3);
        chk("pp_valid", 32'(rd_valid_v[0]), 1);
        chk("pp_data", 32'(rd_data_v[0]), 100);
        for (int i = 1; i < 4; i++) pop_chk(0, 100 + i);

        // reset in the second COMPUTE cycle
        wr(0, 55, 1);
        do_start(0, 6);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy_v[0]), 0);
        chk("mid_rst_count", 32'(res_count_v[0]), 0);
        chk("mid_rst_ovf", 32'(ovf_v[0]), 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_v[0]) seen++;
            tick();
        end
        chk("mid_rst_no_done", seen, 0);
        chk("mid_rst_count_later", 32'(res_count_v[0]), 0);
        wr(0, 7, 1);
        do_start(0, 6);
        pop_chk(0, 7);

        // LANES=1 and LANES=8 builds: A=2..9, B=3
        for (int i = 0; i < 8; i++) wr(i, i + 2, 3);
        do_start(1, 10);
        pop_chk(1, 132);
        do_start(2, 3);
        pop_chk(2, 132);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
